// File: rtl/time_report_tx_pkg.sv
// time_report_tx shared definitions
// state codes, ascii bytes, lengths, digit conversion
package time_report_tx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int unsigned MSG_LEN_SHORT = 6;
  localparam int unsigned MSG_LEN_CRLF  = 8;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] sec_t;
    logic [3:0] sec;
    logic [3:0] tenth;
  } snap_t;

  // BCD digit to printable byte; non-decimal codes become '?'
  function automatic logic [7:0] ascii_digit(
    input logic [3:0] d
  );
    if (d <= 4'd9)
      return ASCII_ZERO | {4'h0, d};
    return ASCII_QMARK;
  endfunction

endpackage

// File: rtl/time_report_tx.sv
// time_report_tx: snapshots stopwatch digits on req
// and streams "M:SS:T" (+CRLF) into a UART TX FIFO
module time_report_tx
  import time_report_tx_pkg::*;
#(
  parameter int unsigned ADD_CRLF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] in3,
  input  logic [3:0] in2,
  input  logic [3:0] in1,
  input  logic [3:0] in0,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       req_dropped
);

  localparam logic [2:0] LAST_IDX =
    (ADD_CRLF != 0) ? 3'(MSG_LEN_CRLF - 1)
                    : 3'(MSG_LEN_SHORT - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  snap_t      snap_q, snap_d;
  logic       wr_en;
  logic [7:0] byte_sel;

  assign wr_en = (state_q == ST_SEND) && !tx_full;

  // next-state: latch snapshot, advance on accepted writes
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          snap_d  = '{min: in3, sec_t: in2,
                      sec: in1, tenth: in0};
          idx_d   = 3'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (wr_en) begin
          if (idx_q == LAST_IDX)
            state_d = ST_FINISH;
          else
            idx_d = idx_q + 3'd1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  // message byte mux indexed by the byte counter
  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      3'd0: byte_sel = ascii_digit(snap_q.min);
      3'd1: byte_sel = ASCII_COLON;
      3'd2: byte_sel = ascii_digit(snap_q.sec_t);
      3'd3: byte_sel = ascii_digit(snap_q.sec);
      3'd4: byte_sel = ASCII_COLON;
      3'd5: byte_sel = ascii_digit(snap_q.tenth);
      3'd6: byte_sel = ASCII_CR;
      3'd7: byte_sel = ASCII_LF;
      default: byte_sel = 8'h00;
    endcase
  end

  // outputs forced quiet while reset is held so an
  // aborted report cannot leak a byte in the reset cycle
  always_comb begin
    wr_uart     = wr_en && !reset;
    wr_data     = wr_uart ? byte_sel : 8'h00;
    busy        = (state_q != ST_IDLE) && !reset;
    done        = (state_q == ST_FINISH) && !reset;
    req_dropped = req && busy;
  end

endmodule

// File: tb/tb_time_report_tx.sv
// time_report_tx bench: CRLF and short variants
// driven side by side with a byte scoreboard each
module tb_time_report_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b, tx_full;
  logic [3:0] in3, in2, in1, in0;
  logic       wr_a, busy_a, done_a, drop_a;
  logic       wr_b, busy_b, done_b, drop_b;
  logic [7:0] data_a, data_b;

  always #5 clk = ~clk;

  time_report_tx #(.ADD_CRLF(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .tx_full(tx_full), .wr_uart(wr_a),
    .wr_data(data_a), .busy(busy_a),
    .done(done_a), .req_dropped(drop_a)
  );

  time_report_tx #(.ADD_CRLF(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .tx_full(tx_full), .wr_uart(wr_b),
    .wr_data(data_b), .busy(busy_b),
    .done(done_b), .req_dropped(drop_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt_a, wr_cnt_b, done_cnt_a, done_cnt_b;
  int done_cyc_a, done_cyc_b, drop_cnt_a, drop_cnt_b;
  int rq;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_ascii(
    input logic [3:0] d
  );
    return (d > 4'd9) ? 8'h3F : 8'h30 + {4'h0, d};
  endfunction

  task automatic push_report();
    logic [7:0] msg[6];
    msg[0] = m_ascii(in3);
    msg[1] = 8'h3A;
    msg[2] = m_ascii(in2);
    msg[3] = m_ascii(in1);
    msg[4] = 8'h3A;
    msg[5] = m_ascii(in0);
    for (int i = 0; i < 6; i++) begin
      exp_a.push_back(msg[i]);
      exp_b.push_back(msg[i]);
    end
    exp_a.push_back(8'h0D);
    exp_a.push_back(8'h0A);
  endtask

  task automatic clr();
    wr_cnt_a = 0; wr_cnt_b = 0;
    done_cnt_a = 0; done_cnt_b = 0;
    done_cyc_a = -1; done_cyc_b = -1;
    drop_cnt_a = 0; drop_cnt_b = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] a, b, c, d);
    in3 = a; in2 = b; in1 = c; in0 = d;
  endtask

  // monitor: pop expected byte on every FIFO write
  always @(negedge clk) begin
    logic [7:0] e;
    if (wr_a) begin
      chk("a_write_while_full", tx_full, 0);
      if (exp_a.size() == 0)
        chk("a_unexpected_write", exp_a.size(), 1);
      else begin
        e = exp_a.pop_front();
        chk("a_byte", data_a, e);
      end
      wr_cnt_a++;
    end else chk("a_idle_data", data_a, 0);
    if (wr_b) begin
      chk("b_write_while_full", tx_full, 0);
      if (exp_b.size() == 0)
        chk("b_unexpected_write", exp_b.size(), 1);
      else begin
        e = exp_b.pop_front();
        chk("b_byte", data_b, e);
      end
      wr_cnt_b++;
    end else chk("b_idle_data", data_b, 0);
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    if (drop_a) drop_cnt_a++;
    if (drop_b) drop_cnt_b++;
  end

  task automatic start_req();
    clr();
    push_report();
    req_a = 1'b1;
    req_b = 1'b1;
    rq = cyc;
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic end_checks(input string tag,
                            input int lat_a,
                            input int lat_b);
    chk({tag, "_wr_cnt_a"}, wr_cnt_a, 8);
    chk({tag, "_wr_cnt_b"}, wr_cnt_b, 6);
    chk({tag, "_done_cnt_a"}, done_cnt_a, 1);
    chk({tag, "_done_cnt_b"}, done_cnt_b, 1);
    chk({tag, "_done_cyc_a"}, done_cyc_a, rq + lat_a);
    chk({tag, "_done_cyc_b"}, done_cyc_b, rq + lat_b);
    chk({tag, "_left_a"}, exp_a.size(), 0);
    chk({tag, "_left_b"}, exp_b.size(), 0);
    chk({tag, "_busy_a"}, busy_a, 0);
  endtask

  initial begin
    clr();
    reset = 1'b1;
    req_a = 1'b1;
    req_b = 1'b1;
    tx_full = 1'b0;
    set_in(4'd1, 4'd2, 4'd3, 4'd4);
    tick();
    tick();
    @(negedge clk);
    chk("rst_outs_a", {wr_a, busy_a, done_a, drop_a}, 0);
    chk("rst_outs_b", {wr_b, busy_b, done_b, drop_b}, 0);
    tick();
    reset = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (3) tick();
    chk("rst_no_report_a", wr_cnt_a + done_cnt_a, 0);

    // basic report, CRLF and short variants
    set_in(4'd3, 4'd4, 4'd5, 4'd7);
    start_req();
    @(negedge clk);
    chk("v1_busy_a", busy_a, 1);
    repeat (11) tick();
    end_checks("v1", 9, 7);

    // backpressure during report cycles 2-5
    set_in(4'd3, 4'd4, 4'd5, 4'd7);
    start_req();
    tick();
    tx_full = 1'b1;
    @(negedge clk);
    chk("v2_hold_wr_a", wr_a, 0);
    chk("v2_hold_busy_a", busy_a, 1);
    repeat (4) tick();
    tx_full = 1'b0;
    repeat (10) tick();
    end_checks("v2", 13, 11);

    // dropped reqs and digit changes mid-report
    set_in(4'd1, 4'd2, 4'd0, 4'd9);
    start_req();
    set_in(4'd8, 4'd8, 4'd8, 4'd8);
    tick();
    tick();
    req_a = 1'b1;
    req_b = 1'b1;
    @(negedge clk);
    chk("v3_drop_a", drop_a, 1);
    chk("v3_drop_b", drop_b, 1);
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (5) tick();
    req_a = 1'b1;
    @(negedge clk);
    chk("v3_finish_done_a", done_a, 1);
    chk("v3_finish_drop_a", drop_a, 1);
    tick();
    req_a = 1'b0;
    repeat (6) tick();
    end_checks("v3", 9, 7);
    chk("v3_drop_cnt_a", drop_cnt_a, 2);
    chk("v3_drop_cnt_b", drop_cnt_b, 1);

    // invalid BCD digits
    set_in(4'hA, 4'h0, 4'hF, 4'h9);
    start_req();
    repeat (11) tick();
    end_checks("v4", 9, 7);

    // reset after the third write
    set_in(4'd2, 4'd5, 4'd1, 4'd3);
    start_req();
    tick();
    tick();
    tick();
    chk("v5_left_a", exp_a.size(), 5);
    chk("v5_left_b", exp_b.size(), 3);
    reset = 1'b1;
    @(negedge clk);
    chk("v5_rst_wr_a", wr_a, 0);
    chk("v5_rst_wr_b", wr_b, 0);
    tick();
    reset = 1'b0;
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
    chk("v5_busy_a", busy_a, 0);
    chk("v5_busy_b", busy_b, 0);
    chk("v5_wr_a", wr_a, 0);
    repeat (5) tick();
    chk("v5_wr_cnt_a", wr_cnt_a, 3);
    chk("v5_wr_cnt_b", wr_cnt_b, 3);
    chk("v5_no_done_a", done_cnt_a, 0);
    chk("v5_no_done_b", done_cnt_b, 0);
    set_in(4'd9, 4'd5, 4'd9, 4'd9);
    start_req();
    repeat (11) tick();
    end_checks("v5_fresh", 9, 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_report_tx.md
TIME_REPORT_TX -- requirements
Module: time_report_tx

Interface
REQ-001 SHALL have parameter ADD_CRLF, default 1: 1 appends CR LF to each report, 0 sends the six time bytes only.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req, input, 1 bit: one-cycle pulse requesting a time report.
REQ-005 SHALL have ports in3, in2, in1, in0, input, 4 bits each: stopwatch BCD digits (minutes, tens of seconds, seconds, tenths).
REQ-006 SHALL have port tx_full, input, 1 bit: UART TX FIFO full flag.
REQ-007 SHALL have port wr_uart, output, 1 bit: TX FIFO write strobe.
REQ-008 SHALL have port wr_data, output, 8 bits: byte written when wr_uart=1.
REQ-009 SHALL have port busy, output, 1 bit: high while a report is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after the last byte is written.
REQ-011 SHALL have port req_dropped, output, 1 bit: one-cycle pulse when req arrives while busy=1.

Function
REQ-012 SHALL implement FSM states IDLE, SEND, FINISH.
REQ-013 IDLE with req=1: SHALL latch in3..in0 into snapshot registers, clear byte index to 0, and go to SEND on the next edge.
REQ-014 Message order SHALL be: ascii(in3), 0x3A, ascii(in2), ascii(in1), 0x3A, ascii(in0), then 0x0D, 0x0A if ADD_CRLF=1 (8 bytes; 6 bytes if ADD_CRLF=0).
REQ-015 ascii(d) SHALL be {4'h3, d} for d in 0..9; for d in 10..15 it SHALL be 0x3F ('?').
REQ-016 In SEND, wr_uart SHALL equal !tx_full (combinational, same-cycle FIFO handshake), and wr_data SHALL be the byte at the current index.
REQ-017 The index SHALL advance only in cycles where wr_uart=1; while tx_full=1 the FSM SHALL hold its index with no write, for any duration.
REQ-018 A write of the last byte SHALL move the FSM to FINISH; FINISH SHALL assert done for one cycle and return to IDLE.
REQ-019 Latency: with tx_full=0 throughout, req in cycle N SHALL give writes in cycles N+1..N+8, done in N+9, and acceptance of a new req from N+10 (ADD_CRLF=1).
REQ-020 busy SHALL be 1 in SEND and FINISH, and 0 in IDLE.
REQ-021 A req arriving while busy=1 (including the FINISH cycle) SHALL be ignored and SHALL pulse req_dropped in the same cycle; the snapshot SHALL be unchanged.
REQ-022 Digit inputs changing during SEND SHALL NOT affect transmitted bytes; the snapshot is authoritative.
REQ-023 wr_data SHALL be 0x00 whenever wr_uart=0.
REQ-024 The byte index SHALL be 3 bits; with ADD_CRLF=0 the last index SHALL be 5, and it SHALL never wrap past the last byte.

Reset
REQ-025 When reset=1 at a clock edge, the FSM SHALL be IDLE, the index 0, and the snapshot 0.
REQ-026 When reset=1 at a clock edge, wr_uart, busy, done and req_dropped SHALL all be 0.
REQ-027 Reset asserted mid-report SHALL abort it with no further writes and no done pulse; req on the cycle reset is asserted SHALL be ignored.

Structure
REQ-028 The shared package SHALL hold the state encoding, the ASCII constants (0x3A, 0x3F, 0x0D, 0x0A, 0x30 base), the message length constants (6 and 8), and the ascii-digit conversion function.
REQ-029 The block SHALL be a single module with no sub-modules; byte selection SHALL be a combinational mux indexed by the byte counter.

Verification
REQ-030 Case V1, basic report: digits 3,4,5,7, ADD_CRLF=1, tx_full=0, req pulse -> bytes 33 3A 34 35 3A 37 0D 0A on consecutive cycles, then done one cycle later.
REQ-031 Case V2, backpressure: tx_full=1 for cycles 2-5 of V1 -> no writes while full, byte order intact, done delayed by exactly 4 cycles.
REQ-032 Case V3, busy handling: req while busy plus digit changes mid-report -> req_dropped pulses, the output matches the original snapshot, and no second report is sent.
REQ-033 Case V4, invalid digits: digit inputs 0xA, 0xF -> byte 0x3F in each affected position.
REQ-034 Case V5, reset mid-report: reset after the 3rd write -> wr_uart=0, busy=0 next cycle, no done; a fresh req then sends a full 8-byte report.
REQ-035 Case V6, short message: ADD_CRLF=0 -> exactly 6 writes, then done.
